alu_mul_seq: RTL and testbench
==============================

// Module: alu_mul_seq
// PURPOSE
//  Sequencer that computes a 32x32 -> low-32 product by driving the shared
//  combinational ALU (A/B/F in, Y out) through shift-and-add iterations.
//  Sits beside EX; muxed onto the ALU ports by the pipeline while busy=1.
//  Low product is identical for signed and unsigned operands (mod 2^32).
// PARAMETERS
//  ITER        32  multiplier bits processed (1..32); bits above ITER-1 ignored
//  EARLY_EXIT  0   1: finish as soon as remaining multiplier is 0
// PORTS
//  clk       in   1   clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  start     in   1   request; sampled only in IDLE or DONE
//  op_a      in   32  multiplicand, captured on accepted start
//  op_b      in   32  multiplier, captured on accepted start
//  busy      out  1   1 in ADD/SHL states
//  done      out  1   1-cycle pulse, DONE state; result valid
//  result    out  32  product, held until next accepted start
//  alu_a     out  32  to ALU A
//  alu_b     out  32  to ALU B
//  alu_f     out  3   to ALU F (010 add, 100 shl)
//  alu_y     in   32  from ALU Y (same-cycle combinational)
// BEHAVIOUR
//  Regs: acc[31:0], mcand[31:0], mplier[31:0], cnt[5:0], state.
//  Reset (async, rst_n=0): state=IDLE, acc/mcand/mplier/cnt=0, result=0;
//   hence busy=0, done=0, alu_a=0, alu_b=0, alu_f=3'b010.
//  States: IDLE, ADD, SHL, DONE. Outputs decoded from registered state only.
//  IDLE: alu_a=0, alu_b=0, alu_f=010. start=1 -> acc=0, mcand=op_a,
//   mplier=op_b, cnt=0, next ADD. start=0 -> stay.
//  ADD: alu_a=acc, alu_b=mcand, alu_f=010.
//   If EXIT -> DONE, no register update. EXIT = (cnt==ITER) or
//   (EARLY_EXIT and mplier==0).
//   Otherwise: if mplier[0], acc<=alu_y, else acc unchanged; next SHL.
//  SHL: alu_a=mcand, alu_b=32'd1, alu_f=100. mcand<=alu_y,
//   mplier<=mplier>>1, cnt<=cnt+1; next ADD.
//  DONE: done=1, busy=0, result<=acc on entry (result already equals acc),
//   ALU ports as IDLE. start=1 -> accepted exactly as in IDLE (back-to-back).
//   start=0 -> IDLE.
//  Latency (EARLY_EXIT=0): start accepted at edge 0 -> ADD/SHL in cycles
//   1..2*ITER, final ADD (exit) in cycle 2*ITER+1, done=1 in cycle 2*ITER+2
//   (66 for ITER=32). Fixed, independent of operands.
//  EARLY_EXIT=1: done in cycle 2k+2, k = min(ITER, index of highest set bit
//   of op_b + 1); op_b=0 -> done in cycle 2.
//  start while busy: ignored, no effect on operands or sequence.
//  Arithmetic wraps mod 2^32; no overflow flag. ALU zero output unused.
//  rst_n low mid-operation: immediate abort to reset values; no done pulse.
//  op_a/op_b may change after acceptance without effect.
// TESTING
//  3*5, EARLY_EXIT=0 -> busy cycles 1..65, done=1 cycle 66 only, result=15.
//  FFFFFFFF*FFFFFFFF -> result=00000001; 00010000*00010000 -> 00000000.
//  ALU port trace for 3*5: F alternates 010/100 from cycle 1, alu_b=1 in SHL.
//  start pulsed in cycle 10 of op 6*7 with op_a=9 -> ignored, result=42.
//  rst_n low in cycle 20 -> busy=0, done=0, result=0 asynchronously;
//   new start 2*2 after release -> result=4.
//  EARLY_EXIT=1: 7*2 -> done cycle 6, result=14; 7*0 -> done cycle 2,
//   result=0; start held high in DONE -> back-to-back op accepted.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer: produces the low 32 bits of op_a*op_b
// by steering the shared combinational ALU through alternating add/shift steps.
module alu_mul_seq #(
   parameter int ITER       = 32,
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y
);

   localparam logic [2:0] F_ADD    = 3'b010;
   localparam logic [2:0] F_SHL    = 3'b100;
   localparam logic [5:0] CNT_LAST = 6'(ITER);

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHL, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] acc, mcand, mplier;
   logic [5:0]  cnt;
   logic        exit_now;

   // Terminate on the ADD visit once every multiplier bit has been consumed.
   assign exit_now = (cnt == CNT_LAST) || (EARLY_EXIT && (mplier == '0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_f     = F_ADD;
      case (state)
         S_IDLE: if (start) state_nxt = S_ADD;
         S_ADD: begin
            busy      = 1'b1;
            alu_a     = acc;
            alu_b     = mcand;
            state_nxt = exit_now ? S_DONE : S_SHL;
         end
         S_SHL: begin
            busy      = 1'b1;
            alu_a     = mcand;
            alu_b     = 32'd1;
            alu_f     = F_SHL;
            state_nxt = S_ADD;
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = start ? S_ADD : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Operand capture is shared by IDLE and DONE so back-to-back starts need no idle cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         result <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  acc    <= '0;
                  mcand  <= op_a;
                  mplier <= op_b;
                  cnt    <= '0;
               end
            end
            S_ADD: begin
               if (exit_now)       result <= acc;
               else if (mplier[0]) acc    <= alu_y;
            end
            S_SHL: begin
               mcand  <= alu_y;
               mplier <= mplier >> 1;
               cnt    <= cnt + 6'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one fixed-latency instance and one early-exit instance,
// each wired to a behavioural ALU, checked against an arithmetic product/timing model.
module tb_alu_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  start_s;
   logic [1:0]  busy_s;
   logic [1:0]  done_s;
   logic [31:0] opa_s [2];
   logic [31:0] opb_s [2];
   logic [31:0] res_s [2];
   logic [31:0] aa_s  [2];
   logic [31:0] ab_s  [2];
   logic [2:0]  af_s  [2];
   logic [31:0] ay_s  [2];
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [2:0] f);
      case (f)
         3'b010:  return a + b;
         3'b100:  return a << b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   assign ay_s[0] = alu(aa_s[0], ab_s[0], af_s[0]);
   assign ay_s[1] = alu(aa_s[1], ab_s[1], af_s[1]);

   alu_mul_seq #(.ITER(32), .EARLY_EXIT(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .op_a(opa_s[0]), .op_b(opb_s[0]),
      .busy(busy_s[0]), .done(done_s[0]), .result(res_s[0]),
      .alu_a(aa_s[0]), .alu_b(ab_s[0]), .alu_f(af_s[0]), .alu_y(ay_s[0]));

   alu_mul_seq #(.ITER(32), .EARLY_EXIT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .op_a(opa_s[1]), .op_b(opb_s[1]),
      .busy(busy_s[1]), .done(done_s[1]), .result(res_s[1]),
      .alu_a(aa_s[1]), .alu_b(ab_s[1]), .alu_f(af_s[1]), .alu_y(ay_s[1]));

   // Start an operation on instance u and follow it to its done pulse.
   // hold keeps start high throughout (ignored while busy, chains in DONE);
   // pulse_cyc raises start for one busy cycle with op_a=9.
   task automatic run_op(input int u, input string name, input logic [31:0] a,
                         input logic [31:0] b, input bit hold, input int pulse_cyc);
      logic [63:0] prod, t, mask;
      logic [31:0] ea, eb;
      logic [2:0]  ef;
      int          k, exp_done, done_cyc, cyc, bad_busy, bad_trace, j;
      prod = {32'd0, a} * {32'd0, b};
      k = 0;
      for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
      exp_done = (u == 0) ? 66 : 2 * k + 2;

      start_s[u] = 1'b1; opa_s[u] = a; opb_s[u] = b;
      @(posedge clk); #1;
      cyc = 1; done_cyc = -1; bad_busy = 0; bad_trace = 0;
      while (done_cyc < 0 && cyc <= 200) begin
         if (busy_s[u] !== (cyc < exp_done)) bad_busy++;
         if (cyc >= exp_done) begin
            ea = 32'd0; eb = 32'd0; ef = 3'b010;
         end else if (cyc % 2 == 1) begin
            j    = (cyc - 1) / 2;
            mask = (64'd1 << j) - 64'd1;
            t    = {32'd0, a} * ({32'd0, b} & mask);
            ea   = t[31:0];
            t    = {32'd0, a} << j;
            eb   = t[31:0];
            ef   = 3'b010;
         end else begin
            j  = cyc / 2 - 1;
            t  = {32'd0, a} << j;
            ea = t[31:0];
            eb = 32'd1;
            ef = 3'b100;
         end
         if (aa_s[u] !== ea || ab_s[u] !== eb || af_s[u] !== ef) bad_trace++;
         if (done_s[u] === 1'b1) done_cyc = cyc;
         else begin
            start_s[u] = hold || (cyc == pulse_cyc);
            opa_s[u]   = (cyc == pulse_cyc) ? 32'd9 : $urandom;
            opb_s[u]   = $urandom;
            @(posedge clk); #1;
            cyc++;
         end
      end

      n_checks++;
      if (done_cyc != exp_done)
         $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
      else n_pass++;
      n_checks++;
      if (res_s[u] !== prod[31:0])
         $display("FAIL %s result: got %08h want %08h", name, res_s[u], prod[31:0]);
      else n_pass++;
      n_checks++;
      if (bad_busy != 0)
         $display("FAIL %s busy_profile: got %0d bad cycles want 0", name, bad_busy);
      else n_pass++;
      n_checks++;
      if (bad_trace != 0)
         $display("FAIL %s alu_trace: got %0d bad cycles want 0", name, bad_trace);
      else n_pass++;

      start_s[u] = hold;
      if (!hold) begin
         @(posedge clk); #1;
         n_checks++;
         if (done_s[u] !== 1'b0 || busy_s[u] !== 1'b0)
            $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done_s[u], busy_s[u]);
         else n_pass++;
         n_checks++;
         if (res_s[u] !== prod[31:0])
            $display("FAIL %s result_held: got %08h want %08h", name, res_s[u], prod[31:0]);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (busy_s[u] !== 1'b0 || done_s[u] !== 1'b0)
            $display("FAIL reset_ctrl%0d: got busy=%b done=%b want 0 0", u, busy_s[u], done_s[u]);
         else n_pass++;
         n_checks++;
         if (res_s[u] !== 32'd0)
            $display("FAIL reset_result%0d: got %08h want 00000000", u, res_s[u]);
         else n_pass++;
         n_checks++;
         if (aa_s[u] !== 32'd0 || ab_s[u] !== 32'd0 || af_s[u] !== 3'b010)
            $display("FAIL reset_alu%0d: got a=%08h b=%08h f=%b want 0 0 010", u, aa_s[u], ab_s[u], af_s[u]);
         else n_pass++;
      end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_fixed_cases();
      run_op(0, "mul_3x5", 32'd3, 32'd5, 1'b0, -1);
      run_op(0, "mul_ones", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, -1);
      run_op(0, "mul_2p16", 32'h00010000, 32'h00010000, 1'b0, -1);
   endtask

   task automatic test_start_ignored();
      run_op(0, "mul_6x7_pulse", 32'd6, 32'd7, 1'b0, 10);
   endtask

   task automatic test_abort();
      start_s[0] = 1'b1; opa_s[0] = 32'h1234; opb_s[0] = 32'h5678;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      n_checks++;
      if (busy_s[0] !== 1'b1) $display("FAIL abort_running: got busy=%b want 1", busy_s[0]);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0)
         $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0", busy_s[0], done_s[0]);
      else n_pass++;
      n_checks++;
      if (res_s[0] !== 32'd0) $display("FAIL abort_result: got %08h want 00000000", res_s[0]);
      else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(0, "after_abort_2x2", 32'd2, 32'd2, 1'b0, -1);
   endtask

   task automatic test_early_exit();
      run_op(1, "ee_7x2", 32'd7, 32'd2, 1'b0, -1);
      run_op(1, "ee_7x0", 32'd7, 32'd0, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      run_op(1, "b2b_first", 32'd11, 32'd13, 1'b1, -1);
      run_op(1, "b2b_second", 32'hDEADBEEF, 32'h00000105, 1'b1, -1);
      run_op(1, "b2b_third", 32'd5, 32'h80000000, 1'b0, -1);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 4; i++) begin
         a = $urandom; b = $urandom;
         run_op(0, "rand_fixed", a, b, 1'b0, -1);
      end
      for (int i = 0; i < 20; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_op(1, "rand_early", a, b, 1'b0, -1);
      end
   endtask

   initial begin
      start_s  = 2'b00;
      opa_s[0] = 32'd0; opa_s[1] = 32'd0;
      opb_s[0] = 32'd0; opb_s[1] = 32'd0;
      test_reset();
      test_fixed_cases();
      test_start_ignored();
      test_abort();
      test_early_exit();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
